// File: rtl/mux_sel_ctrl_pkg.sv
// Shared defaults for the mux select path and board-button debouncing.
// Widths here track the 4-way key/value mux KEY_LEN.
package mux_sel_ctrl_pkg;

    localparam int SEL_W_DEF      = 2;
    localparam int NR_KEY_DEF     = 4;
    localparam int DEB_CYCLES_BTN = 16;
    localparam int SCAN_DIV_DEF   = 1000;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_LOAD,
        UPD_STEP,
        UPD_SCAN
    } upd_src_e;

    // Width of a counter that must hold 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_ctrl_btn_debounce.sv
// Board button conditioner: 2-flop synchronizer, stable-level debounce,
// and rising-edge pulse of the debounced level.
module btn_debounce
    import mux_sel_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_BTN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = cnt_w(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;
    logic             deb_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        deb_nxt = deb;
        cnt_nxt = '0;
        if (s2 != deb) begin
            if (cnt == CNT_LAST) begin
                deb_nxt = s2;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb   <= deb_nxt;
            deb_d <= deb;
            cnt   <= cnt_nxt;
        end
    end

    assign level      = deb;
    assign rise_pulse = deb & ~deb_d;

endmodule

// File: rtl/mux_sel_ctrl.sv
// Select-key generator for the 4-way key/value mux: button step,
// direct switch load and optional auto-scan, arbitrated once per cycle.
module mux_sel_ctrl
    import mux_sel_ctrl_pkg::*;
#(
    parameter int SEL_W      = SEL_W_DEF,
    parameter int NR_KEY     = NR_KEY_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_BTN,
    parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             load_valid,
    input  logic [SEL_W-1:0] load_sel,
    input  logic             auto_en,
    output logic [SEL_W-1:0] sel,
    output logic             sel_chg
);

    localparam int SCAN_W = cnt_w(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NR_KEY - 1);
    localparam logic [SEL_W:0]    NR_KEY_X  = (SEL_W + 1)'(NR_KEY);

    logic              btn_level;
    logic              btn_rise;
    logic              step_req;
    logic              load_ok;
    logic              scan_tick;
    logic              load_win;
    logic              step_win;
    logic              scan_win;
    upd_src_e          upd_src;
    logic [SEL_W-1:0]  sel_inc;
    logic [SEL_W-1:0]  sel_nxt;
    logic              chg_nxt;
    logic [SCAN_W-1:0] scount;
    logic [SCAN_W-1:0] scount_nxt;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (btn_raw),
        .level      (btn_level),
        .rise_pulse (btn_rise)
    );

    assign step_req  = btn_rise & btn_level;
    assign load_ok   = load_valid && ({1'b0, load_sel} < NR_KEY_X);
    assign scan_tick = auto_en && (scount == SCAN_LAST);
    assign sel_inc   = (sel == SEL_LAST) ? '0 : sel + 1'b1;

    // Out-of-range loads fall out of arbitration entirely.
    assign load_win = load_ok;
    assign step_win = step_req & ~load_ok;
    assign scan_win = scan_tick & ~load_ok & ~step_req;

    always_comb begin
        upd_src = UPD_NONE;
        unique case (1'b1)
            load_win: upd_src = UPD_LOAD;
            step_win: upd_src = UPD_STEP;
            scan_win: upd_src = UPD_SCAN;
            default:  upd_src = UPD_NONE;
        endcase
    end

    always_comb begin
        sel_nxt    = sel;
        chg_nxt    = 1'b0;
        scount_nxt = '0;
        if (auto_en && !scan_tick) begin
            scount_nxt = scount + 1'b1;
        end
        unique case (upd_src)
            UPD_LOAD: begin
                sel_nxt    = load_sel;
                chg_nxt    = 1'b1;
                scount_nxt = '0;
            end
            UPD_STEP: begin
                sel_nxt    = sel_inc;
                chg_nxt    = 1'b1;
                scount_nxt = '0;
            end
            UPD_SCAN: begin
                sel_nxt = sel_inc;
                chg_nxt = 1'b1;
            end
            default: begin
                sel_nxt = sel;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= '0;
            sel_chg <= 1'b0;
            scount  <= '0;
        end else begin
            sel     <= sel_nxt;
            sel_chg <= chg_nxt;
            scount  <= scount_nxt;
        end
    end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl: one instance with 4 keys, one with 3,
// sharing stimulus, DEB_CYCLES=4 and SCAN_DIV=5.
module tb_mux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic       load_valid = 1'b0;
    logic [1:0] load_sel = 2'd0;
    logic       auto_en = 1'b0;
    logic [1:0] sel_a;
    logic       chg_a;
    logic [1:0] sel_b;
    logic       chg_b;

    int n_pass = 0;
    int n_total = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    typedef struct {
        logic       lv;
        logic [1:0] ls;
        logic [1:0] ea;
        logic       ca;
        logic [1:0] eb;
        logic       cb;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .SEL_W(2), .NR_KEY(4), .DEB_CYCLES(4), .SCAN_DIV(5)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .load_valid (load_valid),
        .load_sel   (load_sel),
        .auto_en    (auto_en),
        .sel        (sel_a),
        .sel_chg    (chg_a)
    );

    mux_sel_ctrl #(
        .SEL_W(2), .NR_KEY(3), .DEB_CYCLES(4), .SCAN_DIV(5)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .load_valid (load_valid),
        .load_sel   (load_sel),
        .auto_en    (auto_en),
        .sel        (sel_b),
        .sel_chg    (chg_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Each tick ends 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (chg_a) pulses_a++;
            if (chg_b) pulses_b++;
        end
    endtask

    task automatic reset_cycle();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int pa, pb;
        int exp_a [4];
        int exp_b [4];
        exp_a = '{1, 2, 3, 0};
        exp_b = '{1, 2, 0, 1};
        vecs[0] = '{1'b1, 2'd3, 2'd3, 1'b1, 2'd0, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 2'd3, 1'b0, 2'd0, 1'b0};
        vecs[2] = '{1'b1, 2'd2, 2'd2, 1'b1, 2'd2, 1'b1};
        vecs[3] = '{1'b1, 2'd2, 2'd2, 1'b1, 2'd2, 1'b1};
        vecs[4] = '{1'b1, 2'd1, 2'd1, 1'b1, 2'd1, 1'b1};
        vecs[5] = '{1'b0, 2'd3, 2'd1, 1'b0, 2'd1, 1'b0};
        vecs[6] = '{1'b1, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1};

        // reset state and asynchronous reset assertion
        tick(2);
        rst_n = 1'b1;
        chk("rst_sel_a", sel_a, 0);
        chk("rst_chg_a", chg_a, 0);
        auto_en = 1'b1;
        tick(2);
        load_valid = 1'b1;
        load_sel = 2'd2;
        tick(1);
        load_valid = 1'b0;
        chk("pre_rst_sel", sel_a, 2);
        chk("pre_rst_chg", chg_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel_a", sel_a, 0);
        chk("async_rst_chg_a", chg_a, 0);
        chk("async_rst_sel_b", sel_b, 0);
        auto_en = 1'b0;
        tick(2);
        rst_n = 1'b1;

        // held press: single step at edge 7
        pa = pulses_a;
        btn_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            chk($sformatf("press_chg_e%0d", e), chg_a, (e == 7) ? 1 : 0);
            chk($sformatf("press_sel_e%0d", e), sel_a, (e >= 7) ? 1 : 0);
        end
        btn_raw = 1'b0;
        tick(10);
        chk("press_pulses", pulses_a - pa, 1);
        chk("press_sel_b", sel_b, 1);

        // 3-cycle glitch
        pa = pulses_a;
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(12);
        chk("glitch_sel", sel_a, 1);
        chk("glitch_pulses", pulses_a - pa, 0);

        // wrap through four clean presses
        reset_cycle();
        pa = pulses_a;
        pb = pulses_b;
        for (int k = 0; k < 4; k++) begin
            btn_raw = 1'b1;
            tick(8);
            chk($sformatf("wrap_a_%0d", k), sel_a, exp_a[k]);
            chk($sformatf("wrap_b_%0d", k), sel_b, exp_b[k]);
            btn_raw = 1'b0;
            tick(8);
        end
        chk("wrap_pulses_a", pulses_a - pa, 4);
        chk("wrap_pulses_b", pulses_b - pb, 4);

        // table-driven loads
        reset_cycle();
        for (int i = 0; i < 7; i++) begin
            load_valid = vecs[i].lv;
            load_sel = vecs[i].ls;
            tick(1);
            chk($sformatf("vec%0d_sel_a", i), sel_a, vecs[i].ea);
            chk($sformatf("vec%0d_chg_a", i), chg_a, vecs[i].ca);
            chk($sformatf("vec%0d_sel_b", i), sel_b, vecs[i].eb);
            chk($sformatf("vec%0d_chg_b", i), chg_b, vecs[i].cb);
        end
        load_valid = 1'b0;

        // load and step colliding: load wins, step dropped
        pa = pulses_a;
        btn_raw = 1'b1;
        tick(6);
        load_valid = 1'b1;
        load_sel = 2'd2;
        tick(1);
        load_valid = 1'b0;
        chk("coll_sel_a", sel_a, 2);
        chk("coll_chg_a", chg_a, 1);
        chk("coll_sel_b", sel_b, 2);
        tick(1);
        chk("coll_after_sel", sel_a, 2);
        chk("coll_after_chg", chg_a, 0);
        btn_raw = 1'b0;
        tick(8);
        chk("coll_pulses", pulses_a - pa, 1);

        // auto-scan
        reset_cycle();
        auto_en = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick(1);
            chk($sformatf("scan_chg_e%0d", e), chg_a, (e % 5 == 0) ? 1 : 0);
            chk($sformatf("scan_sel_a_e%0d", e), sel_a, e / 5);
            chk($sformatf("scan_sel_b_e%0d", e), sel_b, (e / 5) % 3);
        end
        tick(3);
        chk("scan_pre_load", sel_a, 3);
        load_valid = 1'b1;
        load_sel = 2'd1;
        tick(1);
        load_valid = 1'b0;
        chk("scan_load_sel", sel_a, 1);
        chk("scan_load_chg", chg_a, 1);
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk($sformatf("scan_dwell_chg_%0d", e), chg_a, (e == 5) ? 1 : 0);
        end
        chk("scan_dwell_sel_a", sel_a, 2);
        chk("scan_dwell_sel_b", sel_b, 2);
        pa = pulses_a;
        auto_en = 1'b0;
        tick(12);
        chk("scan_off_sel", sel_a, 2);
        chk("scan_off_pulses", pulses_a - pa, 0);

        // button held through reset
        btn_raw = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("held_rst_sel", sel_a, 0);
        tick(3);
        rst_n = 1'b1;
        pa = pulses_a;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            chk($sformatf("held_chg_e%0d", e), chg_a, (e == 7) ? 1 : 0);
        end
        chk("held_sel", sel_a, 1);
        tick(15);
        chk("held_pulses", pulses_a - pa, 1);
        btn_raw = 1'b0;
        tick(8);
        chk("held_release_pulses", pulses_a - pa, 1);
        btn_raw = 1'b1;
        tick(7);
        chk("repress_sel", sel_a, 2);
        chk("repress_chg", chg_a, 1);
        btn_raw = 1'b0;
        tick(8);
        chk("repress_pulses", pulses_a - pa, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
